// File: rtl/wave_display_multi_if.sv
// wave_display_multi_if
//   Bundles the pixel-scan, sample-RAM and colour-output signals of the
//   multi-channel waveform renderer.
//   Ports (all members):
//     x, y, valid        pixel scan position and visibility
//     read_index, ch_en  buffer select and per-channel enables
//     read_address       shared sample-RAM address (from renderer)
//     read_value         per-channel RAM data, 1 cycle after read_address
//     valid_pixel, r/g/b registered colour output
//   The slave modport is the renderer; the master modport is whoever
//   supplies the scan position and the RAM data.
interface wave_display_multi_if #(
  parameter int NCH      = 2,
  parameter int SAMPLE_W = 8,
  parameter int ADDR_W   = 9
);
  logic [10:0]             x;
  logic [9:0]              y;
  logic                    valid;
  logic                    read_index;
  logic [NCH-1:0]          ch_en;
  logic [ADDR_W-1:0]       read_address;
  logic [NCH*SAMPLE_W-1:0] read_value;
  logic                    valid_pixel;
  logic [7:0]              r;
  logic [7:0]              g;
  logic [7:0]              b;

  modport master (
    output x, y, valid, read_index, ch_en, read_value,
    input  read_address, valid_pixel, r, g, b
  );

  modport slave (
    input  x, y, valid, read_index, ch_en, read_value,
    output read_address, valid_pixel, r, g, b
  );
endinterface

// File: rtl/wave_display_multi.sv
// wave_display_multi
//   Multi-channel waveform renderer for the VGA path. The pixel column is
//   mapped to a shared sample-RAM address; each channel's RAM returns one
//   sample per address. For every pixel a vertical segment is drawn between
//   the channel's previous and current sample. Channel 0 has the highest
//   priority. Buffer index and channel enables are latched at frame start.
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high
//     bus    wave_display_multi_if slave: x/y/valid/read_index/ch_en and
//            read_value in; read_address, valid_pixel, r/g/b out
//   Pixel latency is 2 cycles (address stage, then sample/compare stage).
module wave_display_multi #(
  parameter int              NCH      = 2,
  parameter int              SAMPLE_W = 8,
  parameter int              ADDR_W   = 9,
  parameter int              X_START  = 256,
  parameter int              Y_SHIFT  = 1,
  parameter logic [NCH*24-1:0] CH_COLOR = {24'hFFFF00, 24'h00FFFF}
) (
  input logic                 clk,
  input logic                 reset,
  wave_display_multi_if.slave bus
);

  localparam int WIN_W = 2 ** ADDR_W;
  localparam int WIN_H = 2 ** (SAMPLE_W + Y_SHIFT);
  localparam int SN_W  = ADDR_W - 1;

  // Frame-latched controls
  logic                idx_l_q, idx_l_d;
  logic [NCH-1:0]      en_l_q, en_l_d;

  // Stage 0 (combinational from x/y)
  logic                frame_start;
  logic                idx_eff;
  logic [31:0]         x_ext;
  logic [31:0]         y_ext;
  logic [ADDR_W-1:0]   x_off;
  logic                in_win;
  logic                first;
  logic [SAMPLE_W-1:0] ys;
  logic [ADDR_W-1:0]   addr;

  // Stage 1 registers, aligned with read_value
  logic                s1_in_win_q, s1_in_win_d;
  logic [SAMPLE_W-1:0] s1_ys_q, s1_ys_d;
  logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;
  logic                s1_first_q, s1_first_d;

  // Per-channel sample tracking
  logic [ADDR_W-1:0]                last_addr_q, last_addr_d;
  logic [NCH-1:0][SAMPLE_W-1:0]     prev_q, prev_d;
  logic [NCH-1:0][SAMPLE_W-1:0]     held_q, held_d;
  logic [NCH-1:0][SAMPLE_W-1:0]     cur;
  logic                             new_s;
  logic [23:0]                      color;

  // Output registers
  logic                valid_pixel_q, valid_pixel_d;
  logic [23:0]         rgb_q, rgb_d;

  // Window geometry and address. On a frame-start cycle the incoming
  // read_index is used directly so the latch does not add a frame of lag.
  always_comb begin
    x_ext       = 32'(bus.x);
    y_ext       = 32'(bus.y);
    x_off       = ADDR_W'(x_ext - 32'(X_START));
    frame_start = bus.valid && (bus.x == '0) && (bus.y == '0);
    idx_eff     = frame_start ? bus.read_index : idx_l_q;
    in_win      = bus.valid
                  && (x_ext >= 32'(X_START))
                  && (x_ext < 32'(X_START + WIN_W))
                  && (y_ext < 32'(WIN_H));
    ys          = SAMPLE_W'(y_ext >> Y_SHIFT);
    first       = in_win && (x_off == '0);
    addr        = '0;
    if (in_win) begin
      addr = {idx_eff, x_off[SN_W:1]};
    end
  end

  assign bus.read_address = addr;

  // Frame latch and stage-0 to stage-1 transfer
  always_comb begin
    idx_l_d     = idx_l_q;
    en_l_d      = en_l_q;
    if (frame_start) begin
      idx_l_d = bus.read_index;
      en_l_d  = bus.ch_en;
    end
    s1_in_win_d = in_win;
    s1_ys_d     = ys;
    s1_addr_d   = addr;
    s1_first_d  = first;
  end

  // Sample tracking and hit test. A new sample is detected when the address
  // moves on from the last in-window cycle. On the first column of a row the
  // previous sample is forced to the current one so the last sample of the
  // preceding row does not draw a full-height wrap line. The hit test uses
  // the updated previous value, so the segment appears on the first pixel
  // of the new sample.
  always_comb begin
    cur         = bus.read_value;
    prev_d      = prev_q;
    held_d      = held_q;
    last_addr_d = last_addr_q;
    color       = '0;
    new_s       = s1_in_win_q && ((s1_addr_q != last_addr_q) || s1_first_q);

    if (s1_in_win_q) begin
      last_addr_d = s1_addr_q;
    end

    if (new_s) begin
      held_d = cur;
      for (int c = 0; c < NCH; c++) begin
        prev_d[c] = s1_first_q ? cur[c] : held_q[c];
      end
    end

    // Walk from the highest channel down so channel 0 wins on overlap.
    for (int c = NCH - 1; c >= 0; c--) begin
      logic [SAMPLE_W-1:0] lo;
      logic [SAMPLE_W-1:0] hi;
      lo = (prev_d[c] < cur[c]) ? prev_d[c] : cur[c];
      hi = (prev_d[c] < cur[c]) ? cur[c] : prev_d[c];
      if (en_l_q[c] && (s1_ys_q >= lo) && (s1_ys_q <= hi)) begin
        color = CH_COLOR[24*c +: 24];
      end
    end

    valid_pixel_d = s1_in_win_q;
    rgb_d         = s1_in_win_q ? color : 24'h000000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_l_q       <= 1'b0;
      en_l_q        <= '1;
      s1_in_win_q   <= 1'b0;
      s1_ys_q       <= '0;
      s1_addr_q     <= '0;
      s1_first_q    <= 1'b0;
      last_addr_q   <= '0;
      prev_q        <= '0;
      held_q        <= '0;
      valid_pixel_q <= 1'b0;
      rgb_q         <= '0;
    end else begin
      idx_l_q       <= idx_l_d;
      en_l_q        <= en_l_d;
      s1_in_win_q   <= s1_in_win_d;
      s1_ys_q       <= s1_ys_d;
      s1_addr_q     <= s1_addr_d;
      s1_first_q    <= s1_first_d;
      last_addr_q   <= last_addr_d;
      prev_q        <= prev_d;
      held_q        <= held_d;
      valid_pixel_q <= valid_pixel_d;
      rgb_q         <= rgb_d;
    end
  end

  assign bus.valid_pixel = valid_pixel_q;
  assign bus.r           = rgb_q[23:16];
  assign bus.g           = rgb_q[15:8];
  assign bus.b           = rgb_q[7:0];

endmodule

// File: tb/tb_wave_display_multi.sv
// tb_wave_display_multi
//   Self-checking bench for wave_display_multi. A behavioural model derives
//   each pixel's colour from the RAM contents by sample number; expected
//   results are queued when a pixel is driven and compared two cycles later.
//   A table of hand-computed vectors covers window edges and addressing.
module tb_wave_display_multi;

  localparam int NCH      = 2;
  localparam int SAMPLE_W = 8;
  localparam int ADDR_W   = 9;
  localparam int X_START  = 256;
  localparam int Y_SHIFT  = 1;
  localparam int WIN_W    = 2 ** ADDR_W;
  localparam int WIN_H    = 2 ** (SAMPLE_W + Y_SHIFT);
  localparam int NSAMP    = 2 ** (ADDR_W - 1);

  // Channel 0 yellow, channel 1 cyan.
  localparam logic [NCH*24-1:0] PALETTE = {24'h00FFFF, 24'hFFFF00};
  localparam logic [23:0] YELLOW = 24'hFFFF00;
  localparam logic [23:0] CYAN   = 24'h00FFFF;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic        vp;
    logic [23:0] rgb;
  } sb_t;

  typedef struct {
    int          x;
    int          y;
    bit          v;
    logic [8:0]  exp_addr;
    logic        exp_vp;
    logic [23:0] exp_rgb;
  } vec_t;

  logic clk;
  logic reset;

  wave_display_multi_if #(.NCH(NCH), .SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W)) bus ();

  wave_display_multi #(
    .NCH(NCH), .SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W),
    .X_START(X_START), .Y_SHIFT(Y_SHIFT), .CH_COLOR(PALETTE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [SAMPLE_W-1:0]     ram [NCH][WIN_W];
  logic [NCH*SAMPLE_W-1:0] rv_q;
  logic                    m_idx;
  logic [NCH-1:0]          m_en;
  sb_t                     sb [$];
  int                      check_cnt;
  int                      pass_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample RAM with one cycle of read latency
  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      rv_q[SAMPLE_W*c +: SAMPLE_W] <= ram[c][bus.read_address];
    end
  end
  assign bus.read_value = rv_q;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic fill(input int c, input int bufi, input int val);
    for (int s = 0; s < NSAMP; s++) begin
      ram[c][bufi*NSAMP + s] = SAMPLE_W'(val);
    end
  endtask

  function automatic sb_t model_px(input int px, input int py, input bit pv);
    sb_t e;
    int  n, ys, cur, prv, lo, hi;
    e     = '0;
    e.x   = 11'(px);
    e.y   = 10'(py);
    if (pv && px >= X_START && px < X_START + WIN_W && py < WIN_H) begin
      e.vp = 1'b1;
      n    = (px - X_START) / 2;
      ys   = py >> Y_SHIFT;
      for (int c = NCH - 1; c >= 0; c--) begin
        cur = int'(ram[c][int'(m_idx)*NSAMP + n]);
        prv = (n == 0) ? cur : int'(ram[c][int'(m_idx)*NSAMP + n - 1]);
        lo  = (prv < cur) ? prv : cur;
        hi  = (prv < cur) ? cur : prv;
        if (m_en[c] && ys >= lo && ys <= hi) begin
          e.rgb = PALETTE[24*c +: 24];
        end
      end
    end
    return e;
  endfunction

  // Drives one pixel, queues its expected result (from the model or from
  // the supplied hand-computed values) and compares the result of the pixel
  // driven two cycles earlier.
  task automatic apply_stimulus(input int px, input int py, input bit pv,
                                input bit use_exp, input logic [8:0] e_addr,
                                input logic e_vp, input logic [23:0] e_rgb);
    sb_t e;
    sb_t o;
    bus.x     = 11'(px);
    bus.y     = 10'(py);
    bus.valid = pv;
    if (pv && px == 0 && py == 0) begin
      m_idx = bus.read_index;
      m_en  = bus.ch_en;
    end
    if (use_exp) begin
      e     = '0;
      e.x   = 11'(px);
      e.y   = 10'(py);
      e.vp  = e_vp;
      e.rgb = e_rgb;
    end else begin
      e = model_px(px, py, pv);
    end
    sb.push_back(e);
    #2;
    if (use_exp) begin
      check_output($sformatf("addr x=%0d y=%0d", px, py), 32'(bus.read_address), 32'(e_addr));
    end
    @(posedge clk);
    #1;
    if (sb.size() == 2) begin
      o = sb.pop_front();
      check_output($sformatf("vp x=%0d y=%0d", o.x, o.y), 32'(bus.valid_pixel), 32'(o.vp));
      check_output($sformatf("rgb x=%0d y=%0d", o.x, o.y), {8'h0, bus.r, bus.g, bus.b}, {8'h0, o.rgb});
    end
  endtask

  task automatic scan_row(input int py, input int x0, input int x1);
    for (int px = x0; px <= x1; px++) begin
      apply_stimulus(px, py, 1'b1, 1'b0, '0, 1'b0, '0);
    end
  endtask

  task automatic start_frame(input logic idx, input logic [NCH-1:0] en);
    bus.read_index = idx;
    bus.ch_en      = en;
    apply_stimulus(0, 0, 1'b1, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic idle();
    apply_stimulus(0, 600, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    vec_t tbl [11];
    sb_t  z;

    check_cnt = 0;
    pass_cnt  = 0;
    m_idx     = 1'b0;
    m_en      = '1;

    // Window edges and addressing with buffer 1 latched and only ch0 on
    tbl[0]  = '{255, 10,  1'b1, 9'd0,   1'b0, 24'h0};
    tbl[1]  = '{256, 200, 1'b1, 9'd256, 1'b1, YELLOW};
    tbl[2]  = '{257, 201, 1'b1, 9'd256, 1'b1, YELLOW};
    tbl[3]  = '{258, 202, 1'b1, 9'd257, 1'b1, 24'h0};
    tbl[4]  = '{300, 200, 1'b0, 9'd0,   1'b0, 24'h0};
    tbl[5]  = '{767, 200, 1'b1, 9'd511, 1'b1, YELLOW};
    tbl[6]  = '{768, 200, 1'b1, 9'd0,   1'b0, 24'h0};
    tbl[7]  = '{400, 511, 1'b1, 9'd328, 1'b1, 24'h0};
    tbl[8]  = '{400, 512, 1'b1, 9'd0,   1'b0, 24'h0};
    tbl[9]  = '{401, 399, 1'b1, 9'd328, 1'b1, 24'h0};
    tbl[10] = '{402, 201, 1'b1, 9'd329, 1'b1, YELLOW};

    fill(0, 0, 30);
    fill(1, 0, 200);
    fill(0, 1, 100);
    fill(1, 1, 200);

    reset          = 1'b1;
    bus.x          = '0;
    bus.y          = '0;
    bus.valid      = 1'b0;
    bus.read_index = 1'b0;
    bus.ch_en      = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset vp", 32'(bus.valid_pixel), 32'd0);
    check_output("reset rgb", {8'h0, bus.r, bus.g, bus.b}, 32'd0);
    check_output("reset addr", 32'(bus.read_address), 32'd0);
    reset = 1'b0;

    $display("[TB] window edges and addressing");
    start_frame(1'b1, 2'b01);
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(tbl[i].x, tbl[i].y, tbl[i].v, 1'b1,
                     tbl[i].exp_addr, tbl[i].exp_vp, tbl[i].exp_rgb);
    end

    $display("[TB] flat line");
    for (int py = 199; py <= 202; py++) begin
      scan_row(py, X_START - 2, X_START + WIN_W + 1);
    end

    $display("[TB] step");
    for (int s = 0; s < NSAMP; s++) begin
      ram[0][NSAMP + s] = (s < 20) ? 8'd10 : 8'd50;
    end
    scan_row(18, X_START - 2, X_START + 60);
    scan_row(20, X_START - 2, X_START + 60);
    scan_row(60, X_START - 2, X_START + 60);
    scan_row(100, X_START - 2, X_START + 60);
    scan_row(102, X_START - 2, X_START + 60);

    $display("[TB] priority");
    fill(0, 1, 80);
    fill(1, 1, 80);
    start_frame(1'b1, 2'b11);
    scan_row(160, X_START - 2, 300);
    bus.ch_en = 2'b10;
    scan_row(161, X_START - 2, 300);
    start_frame(1'b1, 2'b10);
    scan_row(160, X_START - 2, 300);

    $display("[TB] buffer switch");
    bus.read_index = 1'b0;
    apply_stimulus(300, 160, 1'b1, 1'b1, 9'd278, 1'b1, CYAN);
    start_frame(1'b0, 2'b10);
    apply_stimulus(302, 40, 1'b1, 1'b1, 9'd23, 1'b1, 24'h0);

    $display("[TB] row wrap");
    fill(0, 1, 0);
    ram[0][NSAMP] = 8'd255;
    start_frame(1'b1, 2'b01);
    scan_row(256, X_START - 2, X_START + WIN_W + 1);
    apply_stimulus(256, 258, 1'b1, 1'b1, 9'd256, 1'b1, 24'h0);
    apply_stimulus(257, 258, 1'b1, 1'b1, 9'd256, 1'b1, 24'h0);
    apply_stimulus(258, 258, 1'b1, 1'b1, 9'd257, 1'b1, YELLOW);
    scan_row(510, X_START - 2, X_START + WIN_W + 1);

    $display("[TB] reset mid-row");
    scan_row(0, X_START - 2, 300);
    bus.x     = 11'd302;
    bus.y     = 10'd0;
    bus.valid = 1'b1;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    check_output("reset mid vp", 32'(bus.valid_pixel), 32'd0);
    check_output("reset mid rgb", {8'h0, bus.r, bus.g, bus.b}, 32'd0);
    reset = 1'b0;
    sb.delete();
    m_idx = 1'b0;
    m_en  = '1;
    z     = '0;
    z.x   = 11'd302;
    sb.push_back(z);
    apply_stimulus(258, 60, 1'b1, 1'b1, 9'd1, 1'b1, YELLOW);
    scan_row(202, X_START - 2, X_START + WIN_W + 1);
    scan_row(60, X_START - 2, X_START + WIN_W + 1);
    idle();
    idle();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/wave_display_multi.md
# wave_display_multi

Multi-channel, parametrised waveform renderer for the VGA path. It maps the pixel scan position (x, y) to a shared sample-RAM address and reads NCH sample streams, one RAM per channel, all at the same address. For each pixel it draws a vertical segment between each channel's previous and current sample. Channels have fixed colours and priority. Buffer index and channel enables are frame-latched so a frame never tears.

## Interface
- NCH, 2: number of channels (1..8)
- SAMPLE_W, 8: bits per sample; unsigned, 0 = top of window
- ADDR_W, 9: RAM address width; MSB is buffer index, low ADDR_W-1 bits are sample number
- X_START, 256: first pixel column of the window; window width is 2^ADDR_W pixels, 2 pixels per sample
- Y_SHIFT, 1: y is right-shifted by Y_SHIFT before comparison; window height is 2^(SAMPLE_W+Y_SHIFT) lines
- CH_COLOR, {24'hFFFF00, 24'h00FFFF}: NCH×24 RGB colours; channel c uses bits [24c+23:24c]

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- x  in  11  pixel column
- y  in  10  pixel row
- valid  in  1  x/y is a visible pixel
- read_index  in  1  buffer to display; sampled at frame start
- ch_en  in  NCH  per-channel enable; sampled at frame start
- read_address  out  ADDR_W  shared RAM address (combinational from x)
- read_value  in  NCH×SAMPLE_W  RAM data; channel c at [SAMPLE_W·c+SAMPLE_W-1 : SAMPLE_W·c]; valid 1 cycle after read_address
- valid_pixel  out  1  registered; rgb is meaningful
- r, g, b  out  8 each  registered colour

## Operation
- **Frame start.** A frame starts on a cycle with valid && x==0 && y==0. On that cycle idx_l <= read_index and en_l <= ch_en. Both hold otherwise. Reset value: idx_l = 0, en_l = all ones.
- **Window geometry.**
  - x_off = x − X_START.
  - in_win = valid && x ≥ X_START && x < X_START+2^ADDR_W && y < 2^(SAMPLE_W+Y_SHIFT).
- **Address.** read_address = {idx_l, x_off[ADDR_W-1:1]} when in_win, else 0.
- **Pipeline.** Stage 0 carries in_win, ys = y>>Y_SHIFT (SAMPLE_W bits), the address, and first = (x_off==0). These are registered into stage 1, aligned with read_value.
- **Per-channel sample tracking (stage 1):**
  - new_s = stage-1 address differs from the address of the previous in-window cycle, or first is set.
  - When new_s and first: prev[c] <= cur, where cur = read_value slice for channel c. This suppresses the wrap line from the previous row.
  - When new_s and not first: prev[c] <= held[c].
  - When new_s: held[c] <= cur.
  - When not new_s: both registers hold.
- **Hit test.** hit[c] = en_l[c] && min(prev[c],cur[c]) ≤ ys ≤ max(prev[c],cur[c]). Comparisons are unsigned, SAMPLE_W bits.
- **Colour.** Lowest-numbered channel with a hit wins and rgb = CH_COLOR[c]. With no hit, or outside the window, rgb = 24'h000000.
- **Valid.** valid_pixel = stage-1 in_win.
- Out-of-window cycles do not modify prev/held.

## Timing
- Read latency is 1 cycle: read_value corresponds to the read_address of the previous cycle.
- Pixel latency is 2 cycles: x/y/valid at cycle t give valid_pixel/r/g/b at cycle t+2.
- **Reset.** Synchronous; all pipeline, prev, held and output registers clear to 0. After reset deasserts, outputs stay 0 until valid pixels have propagated 2 cycles.
  - Reset asserted mid-frame: outputs are 0 on the next edge.
  - idx_l returns to 0 and en_l to all ones.
  - The first row after reset treats its first column as first.
- **Frame-start collisions.** A read_index or ch_en change mid-frame takes effect only at the next frame start. A frame-start cycle uses the newly latched idx_l for its own address: the latch is bypassed on that cycle.
- **Boundaries.**
  - Last window column, x = X_START+2^ADDR_W−1: in_win is 1.
  - Next column: in_win is 0 and read_address is 0.
  - Sample value 2^SAMPLE_W−1 is drawn at ys = max.

## Test plan
- **Flat line.** NCH=2; ch0 RAM = 8'd100 everywhere, ch1 disabled; scan a frame → valid_pixel=1 in the window. rgb=FFFF00 only on rows y=200,201 (Y_SHIFT=1), 0 elsewhere. 2-cycle latency holds.
- **Step.** ch0 samples 10 then 50 at sample n, n+1 → column pixels 2(n+1) and 2(n+1)+1 are lit for ys 10..50 inclusive. Other columns light only their own level.
- **Priority.** Both channels = 8'd80 → pixel colour FFFF00. Clear ch_en[0] before the next frame start → colour 00FFFF from the following frame, unchanged in the current frame.
- **Buffer switch.** Toggle read_index mid-frame → read_address MSB stays at its old value until x=0,y=0. It changes on that exact cycle.
- **Row wrap.** Last sample of a row = 0, first sample = 255 → at column X_START only ys=255 is lit, with no full-height line.
- **Reset.** Assert reset mid-row for 1 cycle → r/g/b/valid_pixel = 0 the next cycle. idx_l = 0. Normal output resumes 2 cycles after valid input.
